// File: rtl/wbxbc_pkg.sv
// Shared types for the Wishbone crossbar pipeline blocks.
//   - default bus widths used by wb_pipe_stage and its benches
//   - wb_req_t: one request-path entry {we, sel, adr, dat, tga, tgc, tgd}
//   - buf_state_e: occupancy of a two-entry skid buffer
package wbxbc_pkg;

   localparam int unsigned WB_ADR_W  = 16;
   localparam int unsigned WB_DAT_W  = 16;
   localparam int unsigned WB_SEL_W  = 2;
   localparam int unsigned WB_TGA_W  = 1;
   localparam int unsigned WB_TGC_W  = 1;
   localparam int unsigned WB_TGRD_W = 1;
   localparam int unsigned WB_TGWD_W = 1;

   // Field order matches the flat payload packed by wb_pipe_stage (we is the MSB).
   typedef struct packed {
      logic                 we;
      logic [WB_SEL_W-1:0]  sel;
      logic [WB_ADR_W-1:0]  adr;
      logic [WB_DAT_W-1:0]  dat;
      logic [WB_TGA_W-1:0]  tga;
      logic [WB_TGC_W-1:0]  tgc;
      logic [WB_TGWD_W-1:0] tgd;
   } wb_req_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } buf_state_e;

endpackage

// File: rtl/wb_skid_buf.sv
// Generic two-entry valid/stall skid buffer.
// Ports:
//   clk       - clock
//   rst_n     - synchronous active-low reset
//   flush     - drop both entries at the next edge (takes priority over accept/drain)
//   in_vld    - upstream offers in_data this cycle
//   in_data   - upstream payload
//   in_stall  - registered back-pressure; 1 exactly while both entries are occupied
//   out_vld   - MAIN entry valid
//   out_data  - MAIN entry payload; stable while out_stall holds it
//   out_stall - downstream back-pressure
module wb_skid_buf
   import wbxbc_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_vld,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_stall,
   output logic             out_vld,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_stall
);

   buf_state_e       state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             stall_q;
   logic             accept;
   logic             drain;

   // stall_q mirrors (state_q == FULL), so nothing is ever accepted in FULL.
   assign accept = in_vld & ~stall_q;
   assign drain  = (state_q != EMPTY) & ~out_stall;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               main_d  = in_data;
               state_d = ONE;
            end
         end
         ONE: begin
            if (accept && drain) begin
               main_d = in_data;
            end else if (accept) begin
               skid_d  = in_data;
               state_d = FULL;
            end else if (drain) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (drain) begin
               main_d  = skid_q;
               state_d = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
      if (flush) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         stall_q <= 1'b0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         stall_q <= (state_d == FULL);
      end
   end

   assign in_stall = stall_q;
   assign out_vld  = (state_q != EMPTY);
   assign out_data = main_q;

endmodule

// File: rtl/wb_pipe_stage.sv
// Registered Wishbone pipeline slice: every path between the initiator side (itr_*) and the
// target side (tgt_*) goes through a register. Requests pass a two-entry skid buffer,
// responses a single register stage. Dropping itr_cyc_i aborts: buffered requests and any
// in-flight responses are discarded at the next edge.
// Ports:
//   clk_i, sync_rst_i            - clock, synchronous active-low reset
//   itr_cyc/stb/we/lock_i        - initiator control
//   itr_sel/adr/dat_i            - initiator request
//   itr_tga/tgc/tgd_i            - initiator tags
//   itr_ack/err/rty/stall_o      - responses and back-pressure to the initiator
//   itr_dat_o, itr_tgd_o         - read data and tag to the initiator
//   tgt_cyc/stb/we/lock_o        - target control
//   tgt_sel/adr/dat/tga/tgc/tgd_o - target request and tags
//   tgt_ack/err/rty/stall_i      - target responses and back-pressure
//   tgt_dat_i, tgt_tgd_i         - target read data and tag
module wb_pipe_stage
   import wbxbc_pkg::*;
#(
   parameter int unsigned ADR_WIDTH  = WB_ADR_W,
   parameter int unsigned DAT_WIDTH  = WB_DAT_W,
   parameter int unsigned SEL_WIDTH  = WB_SEL_W,
   parameter int unsigned TGA_WIDTH  = WB_TGA_W,
   parameter int unsigned TGC_WIDTH  = WB_TGC_W,
   parameter int unsigned TGRD_WIDTH = WB_TGRD_W,
   parameter int unsigned TGWD_WIDTH = WB_TGWD_W
) (
   input  logic                  clk_i,
   input  logic                  sync_rst_i,
   input  logic                  itr_cyc_i,
   input  logic                  itr_stb_i,
   input  logic                  itr_we_i,
   input  logic                  itr_lock_i,
   input  logic [SEL_WIDTH-1:0]  itr_sel_i,
   input  logic [ADR_WIDTH-1:0]  itr_adr_i,
   input  logic [DAT_WIDTH-1:0]  itr_dat_i,
   input  logic [TGA_WIDTH-1:0]  itr_tga_i,
   input  logic [TGC_WIDTH-1:0]  itr_tgc_i,
   input  logic [TGWD_WIDTH-1:0] itr_tgd_i,
   output logic                  itr_ack_o,
   output logic                  itr_err_o,
   output logic                  itr_rty_o,
   output logic                  itr_stall_o,
   output logic [DAT_WIDTH-1:0]  itr_dat_o,
   output logic [TGRD_WIDTH-1:0] itr_tgd_o,
   output logic                  tgt_cyc_o,
   output logic                  tgt_stb_o,
   output logic                  tgt_we_o,
   output logic                  tgt_lock_o,
   output logic [SEL_WIDTH-1:0]  tgt_sel_o,
   output logic [ADR_WIDTH-1:0]  tgt_adr_o,
   output logic [DAT_WIDTH-1:0]  tgt_dat_o,
   output logic [TGA_WIDTH-1:0]  tgt_tga_o,
   output logic [TGC_WIDTH-1:0]  tgt_tgc_o,
   output logic [TGWD_WIDTH-1:0] tgt_tgd_o,
   input  logic                  tgt_ack_i,
   input  logic                  tgt_err_i,
   input  logic                  tgt_rty_i,
   input  logic                  tgt_stall_i,
   input  logic [DAT_WIDTH-1:0]  tgt_dat_i,
   input  logic [TGRD_WIDTH-1:0] tgt_tgd_i
);

   localparam int unsigned REQ_WIDTH =
      1 + SEL_WIDTH + ADR_WIDTH + DAT_WIDTH + TGA_WIDTH + TGC_WIDTH + TGWD_WIDTH;

   logic [REQ_WIDTH-1:0]  req_in;
   logic [REQ_WIDTH-1:0]  req_out;
   logic                  abort;
   logic                  cyc_q, lock_q;
   logic                  ack_q, err_q, rty_q;
   logic                  ack_d, err_d, rty_d;
   logic [DAT_WIDTH-1:0]  rdat_q;
   logic [TGRD_WIDTH-1:0] rtgd_q;

   assign abort  = ~itr_cyc_i;
   assign req_in = {itr_we_i, itr_sel_i, itr_adr_i, itr_dat_i, itr_tga_i, itr_tgc_i, itr_tgd_i};

   wb_skid_buf #(
      .WIDTH (REQ_WIDTH)
   ) u_req_buf (
      .clk       (clk_i),
      .rst_n     (sync_rst_i),
      .flush     (abort),
      .in_vld    (itr_cyc_i & itr_stb_i),
      .in_data   (req_in),
      .in_stall  (itr_stall_o),
      .out_vld   (tgt_stb_o),
      .out_data  (req_out),
      .out_stall (tgt_stall_i)
   );

   assign {tgt_we_o, tgt_sel_o, tgt_adr_o, tgt_dat_o, tgt_tga_o, tgt_tgc_o, tgt_tgd_o} = req_out;

   // Responses only count while both the forwarded cycle and the live initiator cycle are up,
   // so anything arriving during or right after an abort is dropped.
   always_comb begin
      ack_d = tgt_ack_i & cyc_q & itr_cyc_i;
      err_d = tgt_err_i & cyc_q & itr_cyc_i;
      rty_d = tgt_rty_i & cyc_q & itr_cyc_i;
   end

   always_ff @(posedge clk_i) begin
      if (!sync_rst_i) begin
         cyc_q  <= 1'b0;
         lock_q <= 1'b0;
         ack_q  <= 1'b0;
         err_q  <= 1'b0;
         rty_q  <= 1'b0;
         rdat_q <= '0;
         rtgd_q <= '0;
      end else begin
         cyc_q  <= itr_cyc_i;
         lock_q <= itr_lock_i;
         ack_q  <= ack_d;
         err_q  <= err_d;
         rty_q  <= rty_d;
         if (abort) begin
            rdat_q <= '0;
            rtgd_q <= '0;
         end else if (ack_d | err_d | rty_d) begin
            rdat_q <= tgt_dat_i;
            rtgd_q <= tgt_tgd_i;
         end
      end
   end

   assign tgt_cyc_o  = cyc_q;
   assign tgt_lock_o = lock_q;
   assign itr_ack_o  = ack_q;
   assign itr_err_o  = err_q;
   assign itr_rty_o  = rty_q;
   assign itr_dat_o  = rdat_q;
   assign itr_tgd_o  = rtgd_q;

endmodule

// File: doc/wb_pipe_stage.md
# wb_pipe_stage

Registered Wishbone pipeline slice: initiator port (`itr_*`) in, target port (`tgt_*`) out. Sits directly upstream of a pipelined Wishbone target and drives the target-side signals that target's protocol monitor checks. Breaks every combinational path between the two sides:

- request path: two-entry skid buffer;
- response path: one register stage.

Used to close timing on long crossbar-to-target routes.

## Interface
Parameters:
- `ADR_WIDTH`, 16, address bus width
- `DAT_WIDTH`, 16, each data bus width
- `SEL_WIDTH`, 2, number of select lines
- `TGA_WIDTH`, 1, address tag width
- `TGC_WIDTH`, 1, cycle tag width
- `TGRD_WIDTH`, 1, read data tag width
- `TGWD_WIDTH`, 1, write data tag width

Ports:
- `clk_i` in 1: module clock
- `sync_rst_i` in 1: **synchronous, active-low** reset (0 = reset); there is no asynchronous reset
- `itr_cyc_i`, `itr_stb_i`, `itr_we_i`, `itr_lock_i` in 1 each: initiator control
- `itr_sel_i` in SEL_WIDTH, `itr_adr_i` in ADR_WIDTH, `itr_dat_i` in DAT_WIDTH: initiator request
- `itr_tga_i` in TGA_WIDTH, `itr_tgc_i` in TGC_WIDTH, `itr_tgd_i` in TGWD_WIDTH: initiator tags
- `itr_ack_o`, `itr_err_o`, `itr_rty_o`, `itr_stall_o` out 1 each: responses to the initiator
- `itr_dat_o` out DAT_WIDTH, `itr_tgd_o` out TGRD_WIDTH: read data and tags to the initiator
- `tgt_cyc_o`, `tgt_stb_o`, `tgt_we_o`, `tgt_lock_o` out 1 each: target control
- `tgt_sel_o`, `tgt_adr_o`, `tgt_dat_o`, `tgt_tga_o`, `tgt_tgc_o`, `tgt_tgd_o` out: target request and tags (widths as the `itr_` counterparts)
- `tgt_ack_i`, `tgt_err_i`, `tgt_rty_i`, `tgt_stall_i` in 1 each: target responses
- `tgt_dat_i` in DAT_WIDTH, `tgt_tgd_i` in TGRD_WIDTH: target read data and tags

## Operation
Request path, two entries:
- MAIN register drives `tgt_*`. SKID register holds the overflow entry.
- Each entry is `{we, sel, adr, dat, tga, tgc, tgd}` plus a valid bit.
- `tgt_stb_o` = MAIN valid.
- Accept: `itr_cyc_i & itr_stb_i & ~itr_stall_o`.
- Drain: MAIN valid & ~`tgt_stall_i`.
- Request-path states:
  - EMPTY: accept → MAIN.
  - ONE:
    - accept & drain → MAIN reloads from input;
    - accept & ~drain → SKID;
    - drain only → EMPTY.
  - FULL:
    - no accept possible;
    - drain → MAIN ← SKID, go to ONE.
- `itr_stall_o` is registered. It is 1 exactly when the next state is FULL.

Cycle and lock:
- `tgt_cyc_o` and `tgt_lock_o` are `itr_cyc_i` and `itr_lock_i` delayed by one register.

Abort (`itr_cyc_i` = 0):
- Next cycle: both valid bits clear, `tgt_cyc_o` = 0, response registers cleared.
- Any target responses arriving while `itr_cyc_i` = 0 are discarded.

Response path:
- `itr_ack_o`, `itr_err_o`, `itr_rty_o` ← the corresponding `tgt_*_i` & `tgt_cyc_o` & `itr_cyc_i`.
- `itr_dat_o`, `itr_tgd_o` ← `tgt_dat_i`, `tgt_tgd_i`, captured on every cycle in which any of ack/err/rty is 1; otherwise held.
- The block does no reordering or counting; one-hot termination is the target's responsibility.

Reset (`sync_rst_i` = 0 at a clock edge), takes priority over everything:
- all `tgt_*` and `itr_*` outputs are 0, including data and tag outputs;
- both valid bits are 0;
- `itr_stall_o` = 0.

## Timing
- Request latency: accepted at edge N → `tgt_stb_o` is 1 after edge N+1.
- Response latency: `tgt_ack_i` at edge M → `itr_ack_o` after edge M+1.
- Round-trip penalty: +2 cycles versus a direct connection.
- Throughput: one request per cycle while `tgt_stall_i` = 0.
- `tgt_stall_i` rising with ONE entry stored: the next accepted request goes to SKID and `itr_stall_o` asserts one cycle later. No request is lost.
- Simultaneous accept, drain and abort: abort wins and nothing is forwarded.
- Reset mid-cycle: buffered requests are dropped silently.
- MAIN contents stay stable while `tgt_stall_i` = 1. This satisfies the downstream stability rule.

## Structure
- Shared package `wbxbc_pkg`: request-entry struct typedef and the buffer-state encoding `EMPTY`/`ONE`/`FULL`.
- One sub-module: `wb_skid_buf` (the generic two-entry valid/stall buffer, parameterised by payload width), instantiated for the request path.
- Response register stays inline.

## Test plan
1. **Reset:** hold `sync_rst_i` = 0 for 3 cycles while driving `itr_cyc_i` = 1 → all outputs 0; on release `tgt_cyc_o` = 1 one cycle later.
2. **Streaming:** 4 back-to-back writes, adr 0x0010–0x0013, with `tgt_stall_i` = 0 and target acking each the next cycle → `tgt_stb_o` high for 4 consecutive cycles; the 4 `itr_ack_o` pulses start 3 cycles after the first accept; `itr_stall_o` never asserts.
3. **Skid:** raise `tgt_stall_i` for 5 cycles during streaming → exactly two entries held; `itr_stall_o` = 1 until the drain; addresses on `tgt_adr_o` are in order with none dropped or duplicated.
4. **Read data:** a read returns `tgt_dat_i` = 0xBEEF, `tgt_tgd_i` = 1 with `tgt_ack_i` → `itr_dat_o` = 0xBEEF, `itr_tgd_o` = 1 with `itr_ack_o` one cycle later; both held afterwards.
5. **Abort:** drop `itr_cyc_i` with FULL buffer and an ack in flight → next cycle `tgt_cyc_o` = 0, `tgt_stb_o` = 0, and no `itr_ack_o`.
6. **Error and retry:** `tgt_err_i`, then `tgt_rty_i`, on successive requests → `itr_err_o`, then `itr_rty_o`, each exactly one cycle later, one-hot. Bind `wb_tgt_mon` on the `tgt_*` side throughout all scenarios with zero violations.
